// File: rtl/logic_shift.sv
// logic_shift: registered four-mode logical shift/rotate unit.
//
// The operation is picked by a 2-bit select. SHAMT is a fixed distance that
// is set at elaboration time. The output is registered, so the result
// appears one clock after the capturing edge. so_valid is high for the
// cycle that follows an enabled capture.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   en        in   1      capture enable
//   di        in   WIDTH  data in
//   sel       in   2      00 SLL, 01 SRL, 10 ROL, 11 ROR
//   so        out  WIDTH  registered result
//   so_valid  out  1      high for the cycle after an enabled capture
module logic_shift #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHAMT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] di,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] so,
    output logic             so_valid
);

    if (WIDTH < 2) begin : g_bad_width
        $error("logic_shift: WIDTH must be at least 2");
    end
    if (SHAMT > WIDTH - 1) begin : g_bad_shamt
        $error("logic_shift: SHAMT must be in 0..WIDTH-1");
    end

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // The complementary distance for a rotate is WIDTH-SHAMT. When SHAMT is
    // 0 it equals WIDTH. A logical shift by the full width gives zero, so
    // the rotates reduce to a plain pass-through in that case.
    localparam int unsigned RSHAMT = WIDTH - SHAMT;

    logic [WIDTH-1:0] sll_w;
    logic [WIDTH-1:0] srl_w;
    logic [WIDTH-1:0] rol_w;
    logic [WIDTH-1:0] ror_w;

    logic [WIDTH-1:0] so_d;
    logic [WIDTH-1:0] so_q;
    logic             so_valid_d;
    logic             so_valid_q;

    assign sll_w = di << SHAMT;
    assign srl_w = di >> SHAMT;
    assign rol_w = (di << SHAMT) | (di >> RSHAMT);
    assign ror_w = (di >> SHAMT) | (di << RSHAMT);

    always_comb begin
        so_d       = so_q;
        so_valid_d = 1'b0;
        if (en) begin
            so_valid_d = 1'b1;
            unique case (op_e'(sel))
                OP_SLL: so_d = sll_w;
                OP_SRL: so_d = srl_w;
                OP_ROL: so_d = rol_w;
                OP_ROR: so_d = ror_w;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            so_q       <= '0;
            so_valid_q <= 1'b0;
        end else begin
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
        end
    end

    assign so       = so_q;
    assign so_valid = so_valid_q;

endmodule

// File: tb/tb_logic_shift.sv
module tb_logic_shift;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] di;
    logic [1:0] sel;
    logic [7:0] so;
    logic       so_valid;

    int checks;
    int failures;

    logic [7:0] sll_exp [8];
    logic [7:0] srl_exp [8];

    logic_shift #(.WIDTH(8), .SHAMT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .di       (di),
        .sel      (sel),
        .so       (so),
        .so_valid (so_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic e, input logic [7:0] d, input logic [1:0] s);
        @(negedge clk);
        en  = e;
        di  = d;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sll_exp  = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16};
        srl_exp  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4};

        // Reset is held while clock edges arrive with active inputs.
        rst = 1'b1;
        en  = 1'b1;
        di  = 8'hFF;
        sel = 2'b10;
        #1;
        chk("rst_so_async", so, 8'h00);
        chk("rst_valid_async", {7'd0, so_valid}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_so_held", so, 8'h00);
        chk("rst_valid_held", {7'd0, so_valid}, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rol_ff_so", so, 8'hFF);
        chk("rol_ff_valid", {7'd0, so_valid}, 8'h01);

        // SLL
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i + 1), 2'b00);
            chk($sformatf("sll_%0d", i + 1), so, sll_exp[i]);
        end
        step(1'b1, 8'b1000_0011, 2'b00);
        chk("sll_83", so, 8'b0000_0110);

        // SRL
        step(1'b1, 8'b0000_0011, 2'b01);
        chk("srl_03", so, 8'b0000_0001);
        step(1'b1, 8'b1000_0000, 2'b01);
        chk("srl_80_nosign", so, 8'b0100_0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i + 1), 2'b01);
            chk($sformatf("srl_%0d", i + 1), so, srl_exp[i]);
        end

        // Rotates
        step(1'b1, 8'b1000_0001, 2'b10);
        chk("rol_81", so, 8'b0000_0011);
        step(1'b1, 8'b0000_0011, 2'b11);
        chk("ror_03", so, 8'b1000_0001);
        step(1'b1, 8'b0000_0001, 2'b11);
        chk("ror_01", so, 8'b1000_0000);
        step(1'b1, 8'b1011_0100, 2'b10);
        chk("rol_b4", so, 8'b0110_1001);
        step(1'b1, 8'b1011_0100, 2'b11);
        chk("ror_b4", so, 8'b0101_1010);

        // Enable / hold
        step(1'b1, 8'h03, 2'b00);
        chk("hold_cap_so", so, 8'h06);
        chk("hold_cap_valid", {7'd0, so_valid}, 8'h01);
        step(1'b0, 8'hAA, 2'b01);
        chk("hold_so_1", so, 8'h06);
        chk("hold_valid_1", {7'd0, so_valid}, 8'h00);
        #2;
        di  = 8'h5C;
        sel = 2'b10;
        #1;
        chk("hold_midcycle_so", so, 8'h06);
        step(1'b0, 8'hAA, 2'b01);
        chk("hold_so_2", so, 8'h06);
        chk("hold_valid_2", {7'd0, so_valid}, 8'h00);
        step(1'b1, 8'hAA, 2'b01);
        chk("reen_so", so, 8'h55);
        chk("reen_valid", {7'd0, so_valid}, 8'h01);

        // Short reset pulse between edges.
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_so", so, 8'h00);
        chk("midrst_valid", {7'd0, so_valid}, 8'h00);
        rst = 1'b0;
        step(1'b0, 8'h0F, 2'b10);
        chk("postrst_noen_so", so, 8'h00);
        chk("postrst_noen_valid", {7'd0, so_valid}, 8'h00);
        step(1'b1, 8'h0F, 2'b10);
        chk("postrst_load_so", so, 8'h1E);
        chk("postrst_load_valid", {7'd0, so_valid}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_shift.md
Name: logic_shift

Overview:
- Registered 4-mode logical shift/rotate unit on a WIDTH-bit data word.
- A 2-bit opcode selects one of four operations: shift left logical, shift right logical, rotate left, rotate right.
- Result is registered: one-cycle latency, held stable between updates.
- Sits in the datapath as a small ALU-side operand shifter.

Parameters:
- WIDTH, 8, data width in bits; must be ≥2.
- SHAMT, 1, fixed shift/rotate distance in bits; legal range 0..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; result register updates only when en=1.
- di  input  WIDTH  data in.
- sel  input  2  operation select.
- so  output  WIDTH  registered result.
- so_valid  output  1  high for the cycle after an enabled capture, low otherwise.

Behaviour:
- Reset (async, rst=1): so=0 and so_valid=0 immediately. Both stay at 0 while rst is held, regardless of clk, en, di or sel.
- Operation on each rising clk edge with rst=0 and en=1: so <= f(di, sel) and so_valid <= 1.
  - sel=00 SLL: so = di << SHAMT, zero-filled from the LSB end.
  - sel=01 SRL: so = di >> SHAMT, zero-filled from the MSB end. No sign extension.
  - sel=10 ROL: so = {di[WIDTH-1-SHAMT:0], di[WIDTH-1:WIDTH-SHAMT]}.
  - sel=11 ROR: so = {di[SHAMT-1:0], di[WIDTH-1:SHAMT]}.
- Rising clk edge with rst=0 and en=0: so holds its value, so_valid <= 0.
- Latency: exactly 1 clock from the capturing edge to the result on so. Inputs are sampled only at that edge. Input changes between edges have no effect on so.
- SHAMT=0: all four modes pass di through unchanged.
- Bits shifted out are discarded; there is no carry or overflow output.
- Width rules:
  - The result is always exactly WIDTH bits.
  - Zero-fill uses SHAMT bits.
  - Rotates preserve the popcount of di.
- sel is fully decoded. No X or default state can appear on so.
- Reset asserted mid-stream: the pending result is lost. After rst deasserts, so=0 and so_valid=0 until the first enabled edge.
- No internal state other than the so and so_valid registers.

Test Plan:
1. Reset: assert rst with di=8'hFF, sel=10, en=1 -> so=8'h00 and so_valid=0 asynchronously, held through clock edges. Deassert rst -> first enabled edge gives so=8'hFF (ROL of 8'hFF), so_valid=1.
2. SLL: en=1, sel=00, sweep di=1..8 -> so = 2,4,6,8,10,12,14,16 one cycle later. Also di=8'b10000011 -> so=8'b00000110.
3. SRL: sel=01, di=8'b00000011 -> so=8'b00000001. di=8'b10000000 -> so=8'b01000000 (MSB zero-filled, no sign extension). di=1..8 -> 0,1,1,2,2,3,3,4.
4. ROL/ROR:
   - sel=10, di=8'b10000001 -> so=8'b00000011.
   - sel=11, di=8'b00000011 -> so=8'b10000001.
   - sel=11, di=8'b00000001 -> so=8'b10000000.
5. Enable/hold: capture so=8'h06 (sel=00, di=8'h03), then en=0 while changing di to 8'hAA and sel to 01 -> so stays 8'h06 and so_valid=0. Re-enable -> so=8'h55.
6. Mid-operation reset: pulse rst for a fraction of a cycle between edges while so=8'h55 -> so drops to 8'h00 at once. The next enabled edge loads a fresh result.
